add_share_seq: RTL and testbench

//   Sequences and shares the single 64-bit ripple adder (add_64, carry-in fixed 0) between two requesters.

---
 rtl/add_share_seq.sv | 134 +++++++++++++
 tb/tb_add_share_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/add_share_seq.sv
// Shares one 64-bit ripple adder between two requesters. ADD takes one adder pass.
// SUB takes two passes: negate B, then add. The result returns with Y86-64 ZF/SF/OF flags.

module add_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        ovf
);
  always_comb begin
    logic [64:0] c;
    c    = '0;
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < 64; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    // Signed overflow: the carry into the MSB differs from the carry out of it.
    ovf = c[64] ^ c[63];
  end
endmodule

module add_share_seq #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic         req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zf,
  output logic         rsp_sf,
  output logic         rsp_of
);
  typedef enum logic [1:0] {S_IDLE, S_NEG, S_ADD, S_RESP} state_t;

  state_t       state;
  logic         last_grant;
  logic         gnt_idx;
  logic         accept;
  logic         id_reg;
  logic         op_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] b_orig;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] sum;
  logic         add_ovf;
  logic         sub_of;

  // Round robin: on a tie the requester that was not served last wins.
  always_comb begin
    gnt_idx = req_valid[1];
    if (&req_valid) gnt_idx = ~last_grant;
  end

  assign req_ready = (state == S_IDLE && !reset && |req_valid) ? {gnt_idx, ~gnt_idx} : 2'b00;
  assign accept    = |(req_valid & req_ready);

  assign add_a = (state == S_NEG) ? ~b_reg : a_reg;
  assign add_b = (state == S_NEG) ? {{(W-1){1'b0}}, 1'b1} : b_reg;

  add_64 u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (1'b0),
    .sum (sum),
    .ovf (add_ovf)
  );

  // B_reg holds -B during the SUB add pass, so the SUB overflow uses the original B.
  assign sub_of = (a_reg[W-1] != b_orig[W-1]) && (sum[W-1] != a_reg[W-1]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zf     <= 1'b0;
      rsp_sf     <= 1'b0;
      rsp_of     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) state <= (gnt_idx ? req1_op : req0_op) ? S_NEG : S_ADD;
        S_NEG:  state <= S_ADD;
        S_ADD: begin
          rsp_result <= sum;
          rsp_zf     <= (sum == '0);
          rsp_sf     <= sum[W-1];
          rsp_of     <= op_reg ? sub_of : add_ovf;
          rsp_id     <= id_reg;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid  <= 1'b0;
          last_grant <= rsp_id;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: operand latches carry no reset; they are always written before the
  // FSM reads them, so a reset would only add fan-out on the reset net.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_reg <= gnt_idx;
      op_reg <= gnt_idx ? req1_op : req0_op;
      a_reg  <= gnt_idx ? req1_a  : req0_a;
      b_reg  <= gnt_idx ? req1_b  : req0_b;
      b_orig <= gnt_idx ? req1_b  : req0_b;
    end else if (state == S_NEG) begin
      b_reg  <= sum;
    end
  end
endmodule

// File: tb/tb_add_share_seq.sv
// Scoreboard bench for add_share_seq: directed vectors push expectations into a
// queue, and a monitor pops and compares each response as it appears.

module tb_add_share_seq;
  typedef struct {
    logic        id;
    logic [63:0] result;
    logic        zf;
    logic        sf;
    logic        of;
    int          hs_cycle;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic        req0_op = 1'b0, req1_op = 1'b0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_zf, rsp_sf, rsp_of;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cycle    = 0;
  exp_t sb[$];
  exp_t cur;
  bit   active = 0;

  add_share_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
  endtask

  // Monitor: first cycle of a response pops and checks it; later stalled cycles must hold.
  always @(negedge clk) begin
    if (reset) begin
      active = 0;
    end else if (rsp_valid) begin
      if (!active) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
        end else begin
          cur = sb.pop_front();
          active = 1;
          check("rsp_latency", 64'(cycle - cur.hs_cycle), 64'(cur.lat));
          check("rsp_id", {63'd0, rsp_id}, {63'd0, cur.id});
          check("rsp_result", rsp_result, cur.result);
          check("rsp_flags", {61'd0, rsp_zf, rsp_sf, rsp_of}, {61'd0, cur.zf, cur.sf, cur.of});
        end
      end else begin
        check("hold_result", rsp_result, cur.result);
        check("hold_id_flags", {60'd0, rsp_id, rsp_zf, rsp_sf, rsp_of},
              {60'd0, cur.id, cur.zf, cur.sf, cur.of});
      end
      if (rsp_ready) active = 0;
    end
  end

  task automatic issue(input int r, input logic op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input logic zf, input logic sf, input logic of,
                       input bit expect_rsp, output int waited);
    exp_t e;
    @(posedge clk); #1;
    if (r == 0) begin req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_op = op; req1_a = a; req1_b = b; end
    req_valid[r] = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!req_ready[r] && waited < 50);
    check("req_ready", {62'd0, req_ready}, (r == 0) ? 64'd1 : 64'd2);
    if (expect_rsp) begin
      e.id = r[0]; e.result = res; e.zf = zf; e.sf = sf; e.of = of;
      e.hs_cycle = cycle; e.lat = op ? 3 : 2;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || active) && n < 50) begin @(negedge clk); n++; end
    check("drain_timeout", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int w;
    exp_t e;
    logic [1:0] exp_gnt;

    // Reset state, with both requesters asserting: nothing may be accepted.
    req_valid = 2'b11;
    @(negedge clk);
    check("reset_req_ready", {62'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("reset_rsp", {60'd0, rsp_valid, rsp_id, rsp_zf, rsp_sf}, 64'd0);
    check("reset_result_of", {rsp_result[62:0], rsp_of}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors.
    issue(0, 1'b0, 64'd5, 64'd7, 64'd12, 0, 0, 0, 1, w);            drain();
    issue(1, 1'b1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 1, w); drain();
    issue(0, 1'b0, MAX, 64'd1, MIN, 0, 1, 1, 1, w);                 drain();
    issue(1, 1'b1, 64'd0, MIN, MIN, 0, 1, 1, 1, w);                 drain();
    issue(0, 1'b1, 64'h1234, 64'h1234, 64'd0, 1, 0, 0, 1, w);       drain();
    issue(1, 1'b1, MIN, 64'd1, MAX, 0, 0, 1, 1, w);                 drain();
    issue(0, 1'b0, ONES, 64'd1, 64'd0, 1, 0, 0, 1, w);              drain();
    issue(1, 1'b1, 64'd5, 64'd0, 64'd5, 0, 0, 0, 1, w);             drain();

    // After reset a lone req1 is granted on the first IDLE cycle.
    do_reset();
    issue(1, 1'b1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 1, w);
    check("req1_first_wait", 64'(w), 64'd1);
    drain();

    // Round robin with both requesters held valid; reset makes requester 0 first.
    do_reset();
    req0_op = 1'b0; req0_a = 64'd10;  req0_b = 64'd20;
    req1_op = 1'b1; req1_a = 64'd100; req1_b = 64'd1;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 50);
      check("rr_grant", {62'd0, req_ready}, {62'd0, exp_gnt});
      e.id = exp_gnt[1]; e.result = exp_gnt[1] ? 64'd99 : 64'd30;
      e.zf = 0; e.sf = 0; e.of = 0; e.hs_cycle = cycle; e.lat = exp_gnt[1] ? 3 : 2;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    drain();

    // Back-pressure: response held for 5 cycles while a new request waits.
    rsp_ready = 1'b0;
    issue(0, 1'b0, 64'd40, 64'd2, 64'd42, 0, 0, 0, 1, w);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      check("stall_rsp_seen", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk); #1;
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_req_ready", {62'd0, req_ready}, 64'd0);
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    drain();

    // Reset during NEG drops the op; the next request is served normally.
    issue(0, 1'b1, 64'd9, 64'd4, 64'd0, 0, 0, 0, 0, w);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      bit seen = 0;
      for (int k = 0; k < 6; k++) begin @(negedge clk); if (rsp_valid) seen = 1; end
      check("no_rsp_after_reset", 64'(seen), 64'd0);
    end
    issue(0, 1'b0, 64'd1, 64'd2, 64'd3, 0, 0, 0, 1, w);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
